store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two).
REQ-002 Clock  input  1  system clock; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 CpuAdresa  input  16  CPU load/store word address.
REQ-005 CpuWriteData  input  16  CPU store data.
REQ-006 CpuMemWrite  input  1  CPU store request, valid for one cycle per store.
REQ-007 CpuMemRead  input  1  CPU load request.
REQ-008 DrainHold  input  1  1 = pause draining to DataMemory.
REQ-009 CpuReadData  output  16  load result to CPU.
REQ-010 CpuReadValid  output  1  load result valid this cycle.
REQ-011 CpuStall  output  1  store not accepted this cycle; CPU must hold request.
REQ-012 MemAdresa  output  16  address to DataMemory.
REQ-013 MemWriteData  output  16  write data to DataMemory.
REQ-014 MemWrite  output  1  DataMemory write enable; memory writes on rising Clock.
REQ-015 MemRead  output  1  DataMemory read enable; MemReadData valid combinationally in same cycle.
REQ-016 MemReadData  input  16  DataMemory read data.
REQ-017 Count  output  3  occupied entries, 0..DEPTH.
REQ-018 Empty  output  1  Count == 0.

Function
REQ-019 Storage: circular FIFO of {address, data}; head/tail pointers wrap modulo DEPTH; Count tracks occupancy.
REQ-020 Store accept: CpuMemWrite=1 and Count<DEPTH -> enqueue at tail on rising edge, CpuStall=0.
REQ-021 Store full: CpuMemWrite=1 and Count==DEPTH -> CpuStall=1 combinationally, no enqueue; same-cycle drain does not clear stall.
REQ-022 CpuStall=0 whenever CpuMemWrite=0.
REQ-023 Load hit: CpuMemRead=1, CpuMemWrite=0, address matches an entry -> CpuReadData = youngest matching entry data, CpuReadValid=1, MemRead=0, same cycle.
REQ-024 Load miss: no match -> MemRead=1, MemAdresa=CpuAdresa, MemWrite=0, CpuReadData=MemReadData, CpuReadValid=1, same cycle.
REQ-025 Drain: Count>0, DrainHold=0, no load miss this cycle -> MemWrite=1, MemAdresa/MemWriteData = head entry; head dequeues on rising edge; max one drain per cycle.
REQ-026 Priority at memory port: load miss > drain; drain paused that cycle, entry retained.
REQ-027 Load hit does not block drain.
REQ-028 Simultaneous CpuMemWrite=1 and CpuMemRead=1: treated as store only; CpuReadValid=0, no memory read.
REQ-029 Simultaneous enqueue and dequeue: Count unchanged; both pointers advance.
REQ-030 Latency: store accepted at edge N appears on MemWrite no earlier than cycle N+1; no same-cycle pass-through.
REQ-031 Order: stores reach DataMemory in acceptance order.
REQ-032 Idle outputs: when not reading, CpuReadData=0, CpuReadValid=0; when neither MemWrite nor MemRead, MemAdresa=0, MemWriteData=0.

Reset
REQ-033 Reset=1 asynchronously clears pointers and Count, discards all entries; while asserted MemWrite=0, MemRead=0, CpuStall=0, CpuReadValid=0, CpuReadData=0, MemAdresa=0, MemWriteData=0, Count=0, Empty=1.
REQ-034 Reset mid-operation: buffered stores not yet drained are never written to DataMemory.
REQ-035 Operation resumes on first rising edge after Reset deasserts.

Verification
REQ-036 Reset, store addr 12 data 0x0012 -> next cycle MemWrite=1, MemAdresa=12, MemWriteData=0x0012; Count back to 0 after that edge.
REQ-037 DrainHold=1, store (12,0x0012) then (12,0x0034), load 12 -> CpuReadData=0x0034, CpuReadValid=1, MemRead=0.
REQ-038 Buffer holds addr 12, load addr 20 with MemReadData=0x00AB -> MemRead=1, MemAdresa=20, MemWrite=0, CpuReadData=0x00AB; drain of 12 occurs next cycle.
REQ-039 DrainHold=1, stores to 1,2,3,4 -> Count=4; store to 5 -> CpuStall=1, no enqueue; DrainHold=0 -> MemWrite addresses 1,2,3,4 on consecutive cycles, stall drops once Count<4, then 5 is accepted.
REQ-040 DrainHold=1, 3 stores, assert Reset -> Count=0, Empty=1; after release with DrainHold=0, MemWrite stays 0.
REQ-041 CpuMemWrite=1 and CpuMemRead=1 together (addr 7, 0x0077) -> entry enqueued, CpuReadValid=0, MemRead=0.

Source files
------------

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//   Write buffer between a CPU and a single-ported DataMemory. CPU stores are
//   queued in a circular FIFO of {address, data} and drained to memory one per
//   cycle whenever the memory port is free. Loads are served from the youngest
//   matching buffered store (hit) or directly from DataMemory (miss). A load
//   miss owns the memory port that cycle and the drain waits.
//
// Ports
//   Clock, Reset                 rising-edge clock, async active-high reset
//   CpuAdresa, CpuWriteData      CPU word address / store data
//   CpuMemWrite, CpuMemRead      CPU store / load requests
//   DrainHold                    1 = do not drain to DataMemory
//   CpuReadData, CpuReadValid    load result to CPU (same cycle)
//   CpuStall                     store refused (buffer full), CPU holds request
//   MemAdresa, MemWriteData      DataMemory address / write data
//   MemWrite, MemRead            DataMemory enables
//   MemReadData                  DataMemory read data (combinational)
//   Count, Empty                 occupancy, 0..DEPTH
//
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module store_buffer #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [15:0]   CpuAdresa,
  input  logic [15:0]   CpuWriteData,
  input  logic          CpuMemWrite,
  input  logic          CpuMemRead,
  input  logic          DrainHold,
  output logic [15:0]   CpuReadData,
  output logic          CpuReadValid,
  output logic          CpuStall,
  output logic [15:0]   MemAdresa,
  output logic [15:0]   MemWriteData,
  output logic          MemWrite,
  output logic          MemRead,
  input  logic [15:0]   MemReadData,
  output logic [CW-1:0] Count,
  output logic          Empty
);

  logic [15:0]   mem_addr [DEPTH];
  logic [15:0]   mem_data [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          full;
  logic          load, hit, miss, enq, deq;
  logic [15:0]   hit_data;
  logic [AW-1:0] idx;

  assign full = (count == CW'(DEPTH));

  // Outputs must read as idle while Reset is held, so requests are masked.
  assign load = CpuMemRead && !CpuMemWrite && !Reset;
  assign enq  = CpuMemWrite && !full;
  assign miss = load && !hit;
  // Stall depends only on the registered count: a drain in the same cycle
  // frees a slot only after the edge.
  assign deq  = (count != '0) && !DrainHold && !miss && !Reset;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (mem_addr[idx] == CpuAdresa)) begin
        hit      = 1'b1;
        hit_data = mem_data[idx];
      end
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
  end

  // NOTE: the entry storage has no reset; validity comes solely from count,
  // which Reset clears, so stale contents are never observed.
  always_ff @(posedge Clock) begin
    if (enq) begin
      mem_addr[tail] <= CpuAdresa;
      mem_data[tail] <= CpuWriteData;
    end
  end

  always_comb begin
    CpuStall     = CpuMemWrite && full && !Reset;
    CpuReadValid = load;
    CpuReadData  = '0;
    if (load) CpuReadData = hit ? hit_data : MemReadData;

    MemRead      = miss;
    MemWrite     = deq;
    MemAdresa    = '0;
    MemWriteData = '0;
    if (miss) begin
      MemAdresa = CpuAdresa;
    end else if (deq) begin
      MemAdresa    = mem_addr[head];
      MemWriteData = mem_data[head];
    end
  end

  assign Count = count;
  assign Empty = (count == '0);

endmodule

// File: tb/tb_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_store_buffer
//   Drives store_buffer with directed scenarios followed by random traffic.
//   A queue-based reference model computes the expected outputs of every cycle
//   and pushes them to a scoreboard; a monitor on the falling edge pops and
//   compares.
// -----------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] CpuAdresa = '0, CpuWriteData = '0, MemReadData = '0;
  logic        CpuMemWrite = 1'b0, CpuMemRead = 1'b0, DrainHold = 1'b0;
  logic [15:0] CpuReadData, MemAdresa, MemWriteData;
  logic        CpuReadValid, CpuStall, MemWrite, MemRead, Empty;
  logic [2:0]  Count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset),
    .CpuAdresa(CpuAdresa), .CpuWriteData(CpuWriteData),
    .CpuMemWrite(CpuMemWrite), .CpuMemRead(CpuMemRead), .DrainHold(DrainHold),
    .CpuReadData(CpuReadData), .CpuReadValid(CpuReadValid), .CpuStall(CpuStall),
    .MemAdresa(MemAdresa), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemReadData(MemReadData),
    .Count(Count), .Empty(Empty)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } entry_t;

  typedef struct packed {
    logic [2:0]  count;
    logic        empty;
    logic        stall;
    logic        rvalid;
    logic [15:0] rdata;
    logic        mrd;
    logic        mwr;
    logic [15:0] maddr;
    logic [15:0] mwdata;
  } exp_t;

  entry_t model_q[$];
  exp_t   exp_q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One clock cycle: apply inputs, predict outputs from the model, then let
  // the edge happen and advance the model.
  task automatic cycle(input logic rst, input logic wr, input logic rd,
                       input logic [15:0] addr, input logic [15:0] wdata,
                       input logic hold, input logic [15:0] mdata);
    exp_t e;
    logic hit, load, miss, drain, full;
    logic [15:0] hdata;
    Reset = rst; CpuMemWrite = wr; CpuMemRead = rd; CpuAdresa = addr;
    CpuWriteData = wdata; DrainHold = hold; MemReadData = mdata;
    e = '0;
    if (rst) begin
      model_q.delete();
      e.empty = 1'b1;
    end else begin
      full  = (model_q.size() == DEPTH);
      load  = rd && !wr;
      hit   = 1'b0;
      hdata = '0;
      for (int i = model_q.size() - 1; i >= 0; i--) begin
        if (!hit && model_q[i].addr == addr) begin
          hit = 1'b1;
          hdata = model_q[i].data;
        end
      end
      miss  = load && !hit;
      drain = (model_q.size() > 0) && !hold && !miss;
      e.count  = 3'(model_q.size());
      e.empty  = (model_q.size() == 0);
      e.stall  = wr && full;
      e.rvalid = load;
      e.rdata  = load ? (hit ? hdata : mdata) : 16'h0;
      e.mrd    = miss;
      e.mwr    = drain;
      e.maddr  = miss ? addr : (drain ? model_q[0].addr : 16'h0);
      e.mwdata = (!miss && drain) ? model_q[0].data : 16'h0;
      if (drain) void'(model_q.pop_front());
      if (wr && !full) model_q.push_back('{addr: addr, data: wdata});
    end
    exp_q.push_back(e);
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input logic hold);
    cycle(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, hold, 16'h0);
  endtask

  // Monitor: compares DUT outputs mid-cycle against the predicted record.
  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("count",  32'(Count),        32'(e.count));
      check("empty",  32'(Empty),        32'(e.empty));
      check("stall",  32'(CpuStall),     32'(e.stall));
      check("rvalid", 32'(CpuReadValid), 32'(e.rvalid));
      check("rdata",  32'(CpuReadData),  32'(e.rdata));
      check("memrd",  32'(MemRead),      32'(e.mrd));
      check("memwr",  32'(MemWrite),     32'(e.mwr));
      check("maddr",  32'(MemAdresa),    32'(e.maddr));
      check("mwdata", 32'(MemWriteData), 32'(e.mwdata));
    end
  end

  initial begin
    logic stalled;
    logic [15:0] a, d;
    @(posedge Clock);
    #1;
    // Reset state.
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b1, 16'd9, 16'h9, 1'b0, 16'h5);

    // Single store then drain next cycle.
    cycle(1'b0, 1'b1, 1'b0, 16'd12, 16'h0012, 1'b0, 16'h0);
    idle(1'b0);
    idle(1'b0);

    // Youngest-match forwarding.
    cycle(1'b0, 1'b1, 1'b0, 16'd12, 16'h0012, 1'b1, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'd12, 16'h0034, 1'b1, 16'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'd12, 16'h0, 1'b1, 16'hDEAD);
    // Hit does not block drain.
    cycle(1'b0, 1'b0, 1'b1, 16'd12, 16'h0, 1'b0, 16'hDEAD);
    idle(1'b0);
    idle(1'b0);

    // Load miss takes the port; drain follows.
    cycle(1'b0, 1'b1, 1'b0, 16'd12, 16'h0012, 1'b1, 16'h0);
    cycle(1'b0, 1'b0, 1'b1, 16'd20, 16'h0, 1'b0, 16'h00AB);
    idle(1'b0);

    // Fill, stall, drain, then accept the held store.
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i), 16'(i * 16'h11), 1'b1, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'd5, 16'h0055, 1'b1, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'd5, 16'h0055, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'd5, 16'h0055, 1'b0, 16'h0);
    repeat (6) idle(1'b0);

    // Reset discards buffered stores.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 16'(30 + i), 16'(i + 1), 1'b1, 16'h0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 16'h0);
    repeat (4) idle(1'b0);

    // Store and load together: store only.
    cycle(1'b0, 1'b1, 1'b1, 16'd7, 16'h0077, 1'b1, 16'h1234);
    cycle(1'b0, 1'b0, 1'b1, 16'd7, 16'h0, 1'b1, 16'h1234);
    repeat (3) idle(1'b0);

    // Random traffic over a small address space to exercise hits.
    stalled = 1'b0;
    a = '0;
    d = '0;
    for (int n = 0; n < 1500; n++) begin
      logic wr, rd, hold, rst;
      if (!stalled) begin
        a = 16'($urandom_range(0, 7));
        d = 16'($urandom);
      end
      wr   = stalled || ($urandom_range(0, 99) < 45);
      rd   = ($urandom_range(0, 99) < 40);
      hold = ($urandom_range(0, 99) < 35);
      rst  = ($urandom_range(0, 99) < 2);
      stalled = !rst && wr && (model_q.size() == DEPTH);
      cycle(rst, wr, rd, a, d, hold, 16'($urandom));
    end
    idle(1'b0);

    @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
